// File: rtl/aes_uart_pkg.sv
// aes_uart_pkg: state encoding, response byte map and default sizes shared by aes_uart_initiator
package aes_uart_pkg;
    typedef enum logic [2:0] {IDLE, TX_BYTE, TX_HOLD, TX_WAIT, TX_GAP, RX_WAIT, DONE} state_t;
    localparam int PAD0           = 0;
    localparam int PAD1           = 1;
    localparam int STAT           = 2;
    localparam int CT_FIRST       = 3;
    localparam int DEF_REQ_BYTES  = 16;
    localparam int DEF_RESP_BYTES = 19;
endpackage

// File: rtl/aes_uart_initiator_parser.sv
// aes_resp_parser: stores response bytes into result fields by byte index
// Ports: clk/reset (sync, active high); clr wipes all fields at transaction start;
//        we/idx/data write one received byte; ciphertext, glitch_flag, sensor, pad_err are the fields.
module aes_resp_parser
    import aes_uart_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       data,
    output logic [127:0]     ciphertext,
    output logic             glitch_flag,
    output logic [6:0]       sensor,
    output logic             pad_err
);
    logic [127:0] ct_d, ct_q;
    logic [7:0]   stat_d, stat_q;
    logic         pad_d, pad_q;
    // Ciphertext bytes land in fixed lanes so a truncated response leaves the unreceived tail at zero.
    always_comb begin
        ct_d   = clr ? '0 : ct_q;
        stat_d = clr ? '0 : stat_q;
        pad_d  = clr ? 1'b0 : pad_q;
        if (we) begin
            if ((int'(idx) == PAD0 || int'(idx) == PAD1) && data != 8'h00) pad_d = 1'b1;
            if (int'(idx) == STAT) stat_d = data;
            for (int i = 0; i < 16; i++)
                if (int'(idx) == CT_FIRST + i) ct_d[127 - 8*i -: 8] = data;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ct_q   <= '0;
            stat_q <= '0;
            pad_q  <= 1'b0;
        end else begin
            ct_q   <= ct_d;
            stat_q <= stat_d;
            pad_q  <= pad_d;
        end
    end
    assign ciphertext  = ct_q;
    assign glitch_flag = stat_q[7];
    assign sensor      = stat_q[6:0];
    assign pad_err     = pad_q;
endmodule

// File: rtl/aes_uart_initiator.sv
// aes_uart_initiator: sends a 128-bit plaintext as UART bytes and parses the AES target response
// Build macro AES_CT_CHECK_EN adds input expect_ct and output ct_mismatch.
// Ports: clk/reset (sync, active high); start/plaintext/ready request handshake;
//        tx_start/tx_data/tx_busy to the UART transmitter; rx_data_ready/rx_data from the receiver;
//        resp_valid pulse with ciphertext, glitch_flag, sensor, pad_err, timeout results.
module aes_uart_initiator
    import aes_uart_pkg::*;
#(
    parameter int REQ_BYTES      = DEF_REQ_BYTES,
    parameter int RESP_BYTES     = DEF_RESP_BYTES,
    parameter int GAP_CYCLES     = 20000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] plaintext,
    output logic         ready,
    output logic         tx_start,
    output logic [7:0]   tx_data,
    input  logic         tx_busy,
    input  logic         rx_data_ready,
    input  logic [7:0]   rx_data,
    output logic         resp_valid,
    output logic [127:0] ciphertext,
    output logic         glitch_flag,
    output logic [6:0]   sensor,
    output logic         pad_err,
`ifdef AES_CT_CHECK_EN
    input  logic [127:0] expect_ct,
    output logic         ct_mismatch,
`endif
    output logic         timeout
);
    localparam int TX_W  = $clog2(REQ_BYTES + 1);
    localparam int RX_W  = $clog2(RESP_BYTES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    state_t       state_d, state_q;
    logic [127:0] shift_d, shift_q;
    logic [TX_W-1:0]  tx_cnt_d, tx_cnt_q;
    logic [RX_W-1:0]  rx_cnt_d, rx_cnt_q;
    logic [GAP_W-1:0] gap_cnt_d, gap_cnt_q;
    logic [TMO_W-1:0] tmo_cnt_d, tmo_cnt_q;
    logic [7:0]   tx_data_d, tx_data_q;
    logic         tx_start_d, tx_start_q;
    logic         resp_valid_d, resp_valid_q;
    logic         timeout_d, timeout_q;
    logic         ready_d, ready_q;
    logic         clr, rx_we;
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        tx_cnt_d     = tx_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        tx_data_d    = tx_data_q;
        timeout_d    = timeout_q;
        tx_start_d   = 1'b0;
        resp_valid_d = 1'b0;
        clr          = 1'b0;
        rx_we        = 1'b0;
        case (state_q)
            IDLE: if (start && ready_q) begin
                shift_d   = plaintext;
                tx_cnt_d  = '0;
                rx_cnt_d  = '0;
                timeout_d = 1'b0;
                clr       = 1'b1;
                state_d   = TX_BYTE;
            end
            TX_BYTE: if (!tx_busy) begin
                tx_start_d = 1'b1;
                tx_data_d  = shift_q[127:120];
                state_d    = TX_HOLD;
            end
            // One dead cycle so the transmitter can raise tx_busy before it is sampled.
            TX_HOLD: begin
                shift_d  = {shift_q[119:0], 8'h00};
                tx_cnt_d = tx_cnt_q + 1'b1;
                state_d  = TX_WAIT;
            end
            TX_WAIT: if (!tx_busy) begin
                gap_cnt_d = '0;
                state_d   = TX_GAP;
            end
            TX_GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_d == GAP_W'(GAP_CYCLES)) begin
                    tmo_cnt_d = '0;
                    state_d   = tx_cnt_q < TX_W'(REQ_BYTES) ? TX_BYTE : RX_WAIT;
                end
            end
            // A byte arriving on the expiry cycle wins over the timeout.
            RX_WAIT: if (rx_data_ready) begin
                rx_we     = 1'b1;
                rx_cnt_d  = rx_cnt_q + 1'b1;
                tmo_cnt_d = '0;
                if (rx_cnt_d == RX_W'(RESP_BYTES)) state_d = DONE;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (tmo_cnt_d == TMO_W'(TIMEOUT_CYCLES)) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = state_d == IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            tx_cnt_q     <= '0;
            rx_cnt_q     <= '0;
            gap_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            resp_valid_q <= resp_valid_d;
            timeout_q    <= timeout_d;
            ready_q      <= ready_d;
        end
    end
    aes_resp_parser #(.IDX_W(RX_W)) u_parser (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .we         (rx_we),
        .idx        (rx_cnt_q),
        .data       (rx_data),
        .ciphertext (ciphertext),
        .glitch_flag(glitch_flag),
        .sensor     (sensor),
        .pad_err    (pad_err)
    );
`ifdef AES_CT_CHECK_EN
    logic [127:0] exp_d, exp_q;
    logic         ct_mismatch_d, ct_mismatch_q;
    // Evaluated in DONE, when the parser fields and timeout are final.
    always_comb begin
        exp_d         = state_q == IDLE && start ? expect_ct : exp_q;
        ct_mismatch_d = state_q == DONE ? (ciphertext != exp_q) | timeout_q : ct_mismatch_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q         <= '0;
            ct_mismatch_q <= 1'b0;
        end else begin
            exp_q         <= exp_d;
            ct_mismatch_q <= ct_mismatch_d;
        end
    end
    assign ct_mismatch = ct_mismatch_q;
`endif
    assign ready      = ready_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign resp_valid = resp_valid_q;
    assign timeout    = timeout_q;
endmodule

// File: tb/tb_aes_uart_initiator.sv
// tb_aes_uart_initiator: randomized self-checking bench with a UART byte model and response field model
module tb_aes_uart_initiator;
    localparam int GAP   = 20;
    localparam int TMO   = 1000;
    localparam int NREQ  = 16;
    localparam int NRESP = 19;
    localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [151:0] RS1 = 152'h0000053ad77bb40d7a3660a89ecaf32466ef97;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, tx_busy = 1'b0, rx_data_ready = 1'b0;
    logic [127:0] plaintext = '0;
    logic [7:0]   rx_data = '0;
    logic         ready, tx_start, resp_valid, glitch_flag, pad_err, timeout;
    logic [7:0]   tx_data;
    logic [127:0] ciphertext;
    logic [6:0]   sensor;
`ifdef AES_CT_CHECK_EN
    logic [127:0] expect_ct = '0;
    logic         ct_mismatch;
`endif
    int total = 0, bad = 0;
    int cyc = 0, last_tx = 0, min_sp = 0;
    logic [7:0] txq[$];
    logic [7:0] rb [NRESP];

    aes_uart_initiator #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .plaintext    (plaintext),
        .ready        (ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .rx_data_ready(rx_data_ready),
        .rx_data      (rx_data),
        .resp_valid   (resp_valid),
        .ciphertext   (ciphertext),
        .glitch_flag  (glitch_flag),
        .sensor       (sensor),
        .pad_err      (pad_err),
`ifdef AES_CT_CHECK_EN
        .expect_ct    (expect_ct),
        .ct_mismatch  (ct_mismatch),
`endif
        .timeout      (timeout)
    );

    initial forever #5 clk = ~clk;

    // Transmitter model: records each byte and stays busy a few cycles after every tx_start.
    initial begin
        int bcnt;
        bcnt = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (tx_start) begin
                if (txq.size() > 0 && cyc - last_tx < min_sp) min_sp = cyc - last_tx;
                txq.push_back(tx_data);
                last_tx = cyc;
                tx_busy = 1'b1;
                bcnt = 2 + int'($urandom_range(5));
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) tx_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_rb(input logic [151:0] v);
        for (int i = 0; i < NRESP; i++) rb[i] = v[151 - 8*i -: 8];
    endtask

    // Expected ciphertext: response bytes 3..18 in order, unreceived ones as zero.
    function automatic logic [127:0] model_ct(input int n);
        logic [127:0] c;
        c = '0;
        for (int i = 3; i < NRESP; i++) c = {c[119:0], i < n ? rb[i] : 8'h00};
        return c;
    endfunction

    task automatic wait_txq(input int n, input string tag);
        int k;
        k = 0;
        while (txq.size() < n && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, ".tx_progress"}, txq.size() >= n, 1);
    endtask

    task automatic wait_idle_tx();
        int k;
        k = 0;
        while (tx_busy && k < 100) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data = b;
        rx_data_ready = 1'b1;
        @(negedge clk);
        rx_data_ready = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic run_txn(input string tag, input logic [127:0] pt, input int n, input int last_gap,
                           input bit stray, input bit dbl);
        logic [127:0] ect, got;
        logic [7:0]   st;
        int lat, k;
        ect = model_ct(n);
        st  = n > 2 ? rb[2] : 8'h00;
        txq = {};
        min_sp = 1 << 30;
        k = 0;
        while (!ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        plaintext = pt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        plaintext = {$urandom, $urandom, $urandom, $urandom};
        chk({tag, ".ready_low"}, ready, 0);
        chk({tag, ".no_early_tx"}, tx_start, 0);
        if (dbl) begin
            wait_txq(3, tag);
            start = 1'b1;
            plaintext = ~pt;
            @(negedge clk);
            start = 1'b0;
        end
        if (stray) begin
            wait_txq(5, tag);
            wait_idle_tx();
            repeat (3) @(negedge clk);
            rx_byte(8'hFF);
        end
        wait_txq(NREQ, tag);
        wait_idle_tx();
        repeat (GAP + 3) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat ((i == n - 1 ? last_gap : 1 + int'($urandom_range(3))) - 1) @(negedge clk);
            rx_byte(rb[i]);
        end
        lat = 1;
        if (n == NRESP) begin
            rx_data = 8'h5A;
            rx_data_ready = 1'b1;
        end
        while (!resp_valid && lat < TMO + 50) begin
            @(negedge clk);
            rx_data_ready = 1'b0;
            lat++;
        end
        rx_data_ready = 1'b0;
        chk({tag, ".resp_valid"}, resp_valid, 1);
        if (n == NRESP) chk({tag, ".latency"}, lat, 2);
        else chk({tag, ".tmo_latency"}, lat >= TMO && lat <= TMO + 2, 1);
        got = '0;
        foreach (txq[i]) got = {got[119:0], txq[i]};
        chk({tag, ".tx_count"}, txq.size(), NREQ);
        chk({tag, ".tx_bytes"}, got, pt);
        chk({tag, ".tx_spacing"}, min_sp >= GAP, 1);
        chk({tag, ".ciphertext"}, ciphertext, ect);
        chk({tag, ".glitch"}, glitch_flag, st[7]);
        chk({tag, ".sensor"}, sensor, st[6:0]);
        chk({tag, ".pad_err"}, pad_err, (n > 0 && rb[0] != 0) || (n > 1 && rb[1] != 0));
        chk({tag, ".timeout"}, timeout, n < NRESP);
`ifdef AES_CT_CHECK_EN
        chk({tag, ".ct_mismatch"}, ct_mismatch, ect != expect_ct || n < NRESP);
`endif
        @(negedge clk);
        chk({tag, ".pulse_one"}, resp_valid, 0);
        chk({tag, ".ready_back"}, ready, 1);
        chk({tag, ".hold_ct"}, ciphertext, ect);
    endtask

    initial begin
        logic [127:0] rpt;
        int nrv, ntx, rn;
        repeat (3) @(negedge clk);
        chk("rst.ready", ready, 1);
        chk("rst.tx_start", tx_start, 0);
        chk("rst.tx_data", tx_data, 0);
        chk("rst.resp_valid", resp_valid, 0);
        chk("rst.ciphertext", ciphertext, 0);
        chk("rst.glitch", glitch_flag, 0);
        chk("rst.sensor", sensor, 0);
        chk("rst.pad_err", pad_err, 0);
        chk("rst.timeout", timeout, 0);
`ifdef AES_CT_CHECK_EN
        chk("rst.ct_mismatch", ct_mismatch, 0);
`endif
        reset = 1'b0;
        @(negedge clk);
        load_rb(RS1);
`ifdef AES_CT_CHECK_EN
        expect_ct = model_ct(NRESP);
`endif
        run_txn("nominal", PT1, NRESP, 2, 1'b0, 1'b0);
        rb[2] = 8'h8A;
        rb[18] = 8'h96;
        run_txn("glitch", PT1, NRESP, 2, 1'b0, 1'b0);
        load_rb(RS1);
        run_txn("short", PT1, 10, 2, 1'b0, 1'b0);
        rb[1] = 8'hFF;
        run_txn("pad_stray", PT1, NRESP, 3, 1'b1, 1'b0);
        load_rb(RS1);
        txq = {};
        plaintext = PT1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_txq(7, "abort");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort.ready", ready, 1);
        chk("abort.tx_start", tx_start, 0);
        nrv = 0;
        ntx = txq.size();
        repeat (GAP * 3) begin
            @(negedge clk);
            nrv += int'(resp_valid);
        end
        chk("abort.no_resp", nrv, 0);
        chk("abort.no_tx", txq.size(), ntx);
        chk("abort.ready_stays", ready, 1);
        run_txn("rerun", PT1, NRESP, 2, 1'b0, 1'b0);
        run_txn("coincide", PT1, NRESP, TMO, 1'b0, 1'b1);
        for (int t = 0; t < 6; t++) begin
            rpt = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < NRESP; i++) rb[i] = 8'($urandom);
            if ($urandom_range(3) != 0) begin
                rb[0] = 8'h00;
                rb[1] = 8'h00;
            end
            rn = $urandom_range(3) == 0 ? int'($urandom_range(1, NRESP - 1)) : NRESP;
`ifdef AES_CT_CHECK_EN
            expect_ct = $urandom_range(1) == 1 ? model_ct(rn) : {$urandom, $urandom, $urandom, $urandom};
`endif
            run_txn("random", rpt, rn, 1 + int'($urandom_range(3)), $urandom_range(1) == 1, $urandom_range(1) == 1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aes_uart_initiator.md
Name: aes_uart_initiator

Overview:
Host-side initiator for the glitch-detector AES target's UART protocol. It takes a 128-bit plaintext, serialises it as a 16-byte request through the byte-level UART transmitter, then collects and parses the target's 19-byte response into ciphertext, glitch flag and sensor word. It sits on the fault-injection controller FPGA, between the campaign sequencer and the async_transmitter/async_receiver pair.

Parameters:
REQ_BYTES, 16, request length in bytes; plaintext is sent MSB byte first.
RESP_BYTES, 19, response length in bytes.
GAP_CYCLES, 20000, idle clk cycles inserted after each transmitted byte.
TIMEOUT_CYCLES, 2000000, maximum clk cycles between response bytes (and before the first one).

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
start  in  1  request strobe; accepted only when ready=1.
plaintext  in  128  captured on the accepted start.
ready  out  1  high in IDLE only.
tx_start  out  1  one-cycle strobe to the UART transmitter.
tx_data  out  8  byte to transmit; stable while tx_start=1.
tx_busy  in  1  transmitter busy.
rx_data_ready  in  1  one-cycle strobe, received byte valid.
rx_data  in  8  received byte.
resp_valid  out  1  one-cycle pulse when a transaction ends.
ciphertext  out  128  parsed response bytes 3..18, MSB first.
glitch_flag  out  1  response byte 2 bit 7.
sensor  out  7  response byte 2 bits 6:0.
pad_err  out  1  response byte 0 or byte 1 was nonzero.
timeout  out  1  transaction ended by timeout.

Behaviour:
- Reset: return to IDLE; ready=1; tx_start=0; tx_data=0; resp_valid=0; ciphertext=0; glitch_flag=0; sensor=0; pad_err=0; timeout=0; all counters cleared.
- Reset mid-transaction: abort immediately. No resp_valid is issued. A byte the transmitter already has in progress completes on its own.
- IDLE: on start&ready, latch plaintext into the shift register. Clear byte counters, pad_err and timeout. Go to TX_BYTE.
- TX_BYTE: wait for tx_busy=0. Drive tx_data = shift[127:120] and pulse tx_start for one cycle. Go to TX_HOLD.
- TX_HOLD: hold one cycle to let tx_busy rise. Shift left by 8. Increment tx_cnt. Go to TX_WAIT.
- TX_WAIT: when tx_busy=0, go to TX_GAP.
- TX_GAP: count GAP_CYCLES. Then go to TX_BYTE if tx_cnt<REQ_BYTES, else go to RX_WAIT.
- RX_WAIT: each rx_data_ready stores rx_data by index rx_cnt:
  - 0 or 1: padding; a nonzero value sets pad_err.
  - 2: {glitch_flag, sensor}.
  - 3..18: shifted into ciphertext MSB first.
  - The timeout counter reloads on every received byte.
  - When rx_cnt reaches RESP_BYTES, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES, set timeout=1 and go to DONE. Partial fields keep whatever was received; unreceived bytes read 0.
- DONE: pulse resp_valid for one cycle, then return to IDLE. Outputs hold until the next accepted start.
- Boundaries:
  - rx_data_ready outside RX_WAIT is discarded, including during TX_GAP.
  - A byte strobe in the same cycle as timeout expiry is accepted and the timeout is cancelled.
  - Bytes beyond RESP_BYTES are ignored.
  - start while ready=0 is ignored.
- Latency: first tx_start occurs at least 2 cycles after the accepted start. resp_valid occurs 2 cycles after the 19th rx_data_ready.
- All counters are sized with $clog2 of their limit + 1 and never wrap.

Optional Feature:
AES_CT_CHECK_EN:
- Defined: adds input expect_ct[127:0], latched with plaintext on the accepted start, and output ct_mismatch. In DONE, ct_mismatch = (ciphertext != expect_ct) | timeout; it is valid alongside resp_valid and resets to 0.
- Undefined: neither port exists and no comparator is built.

Decomposition:
- Package aes_uart_pkg holds:
  - the state enum (IDLE, TX_BYTE, TX_HOLD, TX_WAIT, TX_GAP, RX_WAIT, DONE);
  - localparams for byte indices PAD0=0, PAD1=1, STAT=2, CT_FIRST=3;
  - default REQ_BYTES/RESP_BYTES.
- One sub-module, aes_resp_parser: byte index in, field registers and pad_err out. The FSM and counters stay in the top.

Test Plan:
1. Nominal: plaintext 6bc1bee22e409f96e93d7e117393172a with a UART model echoing 00 00 05 3ad77bb40d7a3660a89ecaf32466ef97 -> tx sees 6b first and 2a last, 16 tx_start with ≥GAP_CYCLES spacing; resp_valid=1, ciphertext=3ad77bb4…ef97, glitch_flag=0, sensor=05, pad_err=0, timeout=0.
2. Glitch status byte 0x8A -> glitch_flag=1, sensor=0x0A; with AES_CT_CHECK_EN and expect_ct=3ad77bb4…ef97 against returned ct …ef96 -> ct_mismatch=1.
3. Model returns only 10 bytes (TIMEOUT_CYCLES=1000) -> resp_valid 1000 cycles after byte 10, timeout=1, ciphertext[127:72]=bytes 3..9, rest 0.
4. Padding byte 1 = 0xFF -> pad_err=1, other fields correct; stray rx byte injected during TX_GAP -> ignored, field alignment intact.
5. Reset asserted after byte 7 is sent -> ready=1 next cycle, no resp_valid, tx_start stays 0; a fresh start then completes scenario 1.
6. start pulsed while busy plus a byte strobe coinciding with timeout expiry -> second start ignored; the coincident byte is accepted and timeout stays 0.
